// File: rtl/decode_fetch_ctrl.sv
// rtl/decode_fetch_ctrl.sv - decode-to-fetch feedback: stall, flush, redirect and halt control
// Mealy outputs from state plus current inputs; stall_cnt counts fetch-stalled cycles outside HALT.
module decode_fetch_ctrl #(
  parameter int LU_STALL_CYC = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fd_valid,
  input  logic [2:0]       dec_rs,
  input  logic             dec_rs_used,
  input  logic [2:0]       dec_rt,
  input  logic             dec_rt_used,
  input  logic [2:0]       idex_rd,
  input  logic             idex_is_load,
  input  logic             idex_valid,
  input  logic             br_taken,
  input  logic [15:0]      br_target,
  input  logic             dec_halt,
  input  logic             imem_stall,
  output logic             pc_we,
  output logic             fd_we,
  output logic             fd_flush,
  output logic             idex_bubble,
  output logic             redirect_valid,
  output logic [15:0]      redirect_pc,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int LU_W = (LU_STALL_CYC > 1) ? $clog2(LU_STALL_CYC) : 1;
  localparam logic [LU_W-1:0] LU_LOAD = LU_W'(LU_STALL_CYC - 1);
  localparam bit LU_MULTI = (LU_STALL_CYC > 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_LU_STALL,
    S_REDIR_PEND,
    S_HALT
  } state_t;

  state_t           state_q, state_d;
  logic [LU_W-1:0]  lu_cnt_q, lu_cnt_d;
  logic [15:0]      redir_pc_q, redir_pc_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             hazard;

  always_comb begin
    hazard = fd_valid & idex_valid & idex_is_load &
             ((dec_rs_used & (dec_rs == idex_rd)) | (dec_rt_used & (dec_rt == idex_rd)));

    state_d        = state_q;
    lu_cnt_d       = lu_cnt_q;
    redir_pc_d     = redir_pc_q;
    pc_we          = 1'b1;
    fd_we          = 1'b1;
    fd_flush       = 1'b0;
    idex_bubble    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = br_target;

    case (state_q)
      S_RUN: begin
        if (fd_valid && dec_halt) begin
          pc_we    = 1'b0;
          fd_flush = 1'b1;
          state_d  = S_HALT;
        end else if (hazard) begin
          pc_we       = 1'b0;
          fd_we       = 1'b0;
          idex_bubble = 1'b1;
          if (LU_MULTI) begin
            lu_cnt_d = LU_LOAD;
            state_d  = S_LU_STALL;
          end
        end else if (fd_valid && br_taken && !imem_stall) begin
          redirect_valid = 1'b1;
          fd_flush       = 1'b1;
        end else if (fd_valid && br_taken) begin
          // Fetch is still busy; remember the target and fire once imem returns.
          redir_pc_d = br_target;
          pc_we      = 1'b0;
          fd_flush   = 1'b1;
          state_d    = S_REDIR_PEND;
        end else if (imem_stall) begin
          pc_we    = 1'b0;
          fd_flush = 1'b1;
        end
      end
      S_LU_STALL: begin
        pc_we       = 1'b0;
        fd_we       = 1'b0;
        idex_bubble = 1'b1;
        lu_cnt_d    = lu_cnt_q - 1'b1;
        if (lu_cnt_q <= LU_W'(1)) begin
          state_d = S_RUN;
        end
      end
      S_REDIR_PEND: begin
        fd_flush    = 1'b1;
        redirect_pc = redir_pc_q;
        if (imem_stall) begin
          pc_we = 1'b0;
        end else begin
          redirect_valid = 1'b1;
          state_d        = S_RUN;
        end
      end
      S_HALT: begin
        pc_we    = 1'b0;
        fd_flush = 1'b1;
      end
      default: state_d = S_RUN;
    endcase

    if (rst) begin
      pc_we          = 1'b0;
      fd_we          = 1'b1;
      fd_flush       = 1'b1;
      idex_bubble    = 1'b1;
      redirect_valid = 1'b0;
    end

    stall_cnt_d = stall_cnt_q;
    if (!pc_we && (state_q != S_HALT) && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RUN;
      lu_cnt_q    <= '0;
      redir_pc_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      lu_cnt_q    <= lu_cnt_d;
      redir_pc_q  <= redir_pc_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign halted    = (state_q == S_HALT);
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_decode_fetch_ctrl.sv
// tb/tb_decode_fetch_ctrl.sv - self-checking bench for decode_fetch_ctrl
// Cycle table with a scoreboard queue, plus a hand sequence on a second instance (LU=3, CNT_W=2).
module tb_decode_fetch_ctrl;

  typedef struct packed {
    logic        rst;
    logic        fdv;
    logic [2:0]  rs;
    logic        rsu;
    logic [2:0]  rt;
    logic        rtu;
    logic [2:0]  rd;
    logic        ld;
    logic        iv;
    logic        bt;
    logic [15:0] tgt;
    logic        hlt;
    logic        ims;
  } in_t;

  // f = {pc_we, fd_we, fd_flush, idex_bubble, redirect_valid}
  typedef struct packed {
    logic [4:0]  f;
    logic [15:0] rpc;
    logic        hlt;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    string nm;
    in_t   i;
    exp_t  e;
  } vec_t;

  localparam logic [4:0] F_RUN = 5'b11000;
  localparam logic [4:0] F_RST = 5'b01110;
  localparam logic [4:0] F_LU  = 5'b00010;
  localparam logic [4:0] F_RED = 5'b11101;
  localparam logic [4:0] F_STL = 5'b01100;

  logic        clk = 1'b0;
  logic        rst;
  logic        fd_valid, dec_rs_used, dec_rt_used, idex_is_load, idex_valid;
  logic        br_taken, dec_halt, imem_stall;
  logic [2:0]  dec_rs, dec_rt, idex_rd;
  logic [15:0] br_target;
  logic        pc_we, fd_we, fd_flush, idex_bubble, redirect_valid, halted;
  logic [15:0] redirect_pc;
  logic [15:0] stall_cnt;
  logic        pc_we2, fd_we2, fd_flush2, idex_bubble2, redirect_valid2, halted2;
  logic [15:0] redirect_pc2;
  logic [1:0]  stall_cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  vec_t tbl[$];
  exp_t sb[$];

  decode_fetch_ctrl #(.LU_STALL_CYC(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .fd_valid(fd_valid),
    .dec_rs(dec_rs), .dec_rs_used(dec_rs_used), .dec_rt(dec_rt), .dec_rt_used(dec_rt_used),
    .idex_rd(idex_rd), .idex_is_load(idex_is_load), .idex_valid(idex_valid),
    .br_taken(br_taken), .br_target(br_target), .dec_halt(dec_halt), .imem_stall(imem_stall),
    .pc_we(pc_we), .fd_we(fd_we), .fd_flush(fd_flush), .idex_bubble(idex_bubble),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted),
    .stall_cnt(stall_cnt)
  );

  decode_fetch_ctrl #(.LU_STALL_CYC(3), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .fd_valid(fd_valid),
    .dec_rs(dec_rs), .dec_rs_used(dec_rs_used), .dec_rt(dec_rt), .dec_rt_used(dec_rt_used),
    .idex_rd(idex_rd), .idex_is_load(idex_is_load), .idex_valid(idex_valid),
    .br_taken(br_taken), .br_target(br_target), .dec_halt(dec_halt), .imem_stall(imem_stall),
    .pc_we(pc_we2), .fd_we(fd_we2), .fd_flush(fd_flush2), .idex_bubble(idex_bubble2),
    .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2), .halted(halted2),
    .stall_cnt(stall_cnt2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic in_t idle();
    in_t r;
    r     = '0;
    r.fdv = 1'b1;
    return r;
  endfunction

  function automatic in_t hz(input logic [2:0] rs, input logic rsu,
                             input logic [2:0] rt, input logic rtu);
    in_t r;
    r     = idle();
    r.rd  = 3'd3;
    r.ld  = 1'b1;
    r.iv  = 1'b1;
    r.rs  = rs;
    r.rsu = rsu;
    r.rt  = rt;
    r.rtu = rtu;
    return r;
  endfunction

  function automatic in_t br(input logic [15:0] tgt, input logic ims);
    in_t r;
    r     = idle();
    r.bt  = 1'b1;
    r.tgt = tgt;
    r.ims = ims;
    return r;
  endfunction

  task automatic add(input string nm, input in_t i, input logic [4:0] f,
                     input logic [15:0] rpc, input logic hlt, input logic [15:0] cnt);
    vec_t v;
    v.nm    = nm;
    v.i     = i;
    v.e.f   = f;
    v.e.rpc = rpc;
    v.e.hlt = hlt;
    v.e.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic drive(input in_t i);
    rst          = i.rst;
    fd_valid     = i.fdv;
    dec_rs       = i.rs;
    dec_rs_used  = i.rsu;
    dec_rt       = i.rt;
    dec_rt_used  = i.rtu;
    idex_rd      = i.rd;
    idex_is_load = i.ld;
    idex_valid   = i.iv;
    br_taken     = i.bt;
    br_target    = i.tgt;
    dec_halt     = i.hlt;
    imem_stall   = i.ims;
  endtask

  initial begin
    in_t  t;
    in_t  rst_in;
    exp_t e;

    rst_in     = idle();
    rst_in.rst = 1'b1;

    add("reset",        rst_in,                         F_RST, 16'h0000, 1'b0, 16'd0);
    add("idle0",        idle(),                         F_RUN, 16'h0000, 1'b0, 16'd0);
    add("lu_detect",    hz(3'd3, 1'b1, 3'd0, 1'b0),     F_LU,  16'h0000, 1'b0, 16'd0);
    add("lu_hold",      hz(3'd3, 1'b1, 3'd0, 1'b0),     F_LU,  16'h0000, 1'b0, 16'd1);
    add("lu_done",      idle(),                         F_RUN, 16'h0000, 1'b0, 16'd2);
    add("rs_unused",    hz(3'd3, 1'b0, 3'd3, 1'b0),     F_RUN, 16'h0000, 1'b0, 16'd2);
    t = hz(3'd3, 1'b1, 3'd0, 1'b0); t.iv = 1'b0;
    add("idex_invalid", t,                              F_RUN, 16'h0000, 1'b0, 16'd2);
    t = hz(3'd3, 1'b1, 3'd0, 1'b0); t.ld = 1'b0;
    add("not_load",     t,                              F_RUN, 16'h0000, 1'b0, 16'd2);
    t = hz(3'd3, 1'b1, 3'd0, 1'b0); t.fdv = 1'b0;
    add("fd_invalid",   t,                              F_RUN, 16'h0000, 1'b0, 16'd2);
    add("rt_detect",    hz(3'd5, 1'b1, 3'd3, 1'b1),     F_LU,  16'h0000, 1'b0, 16'd2);
    add("rt_hold",      idle(),                         F_LU,  16'h0000, 1'b0, 16'd3);
    add("rt_done",      idle(),                         F_RUN, 16'h0000, 1'b0, 16'd4);
    t = idle(); t.hlt = 1'b1; t.fdv = 1'b0;
    add("halt_invalid", t,                              F_RUN, 16'h0000, 1'b0, 16'd4);
    add("br_now",       br(16'h0040, 1'b0),             F_RED, 16'h0040, 1'b0, 16'd4);
    t = br(16'h0040, 1'b0); t.fdv = 1'b0;
    add("br_invalid",   t,                              F_RUN, 16'h0040, 1'b0, 16'd4);
    add("brp_detect",   br(16'h0040, 1'b1),             F_STL, 16'h0040, 1'b0, 16'd4);
    t = idle(); t.ims = 1'b1; t.tgt = 16'h1234;
    add("brp_wait1",    t,                              F_STL, 16'h0040, 1'b0, 16'd5);
    add("brp_wait2",    t,                              F_STL, 16'h0040, 1'b0, 16'd6);
    add("brp_fire",     br(16'h1234, 1'b0),             F_RED, 16'h0040, 1'b0, 16'd7);
    add("brp_after",    idle(),                         F_RUN, 16'h0000, 1'b0, 16'd7);
    t = idle(); t.ims = 1'b1;
    add("imem_stall",   t,                              F_STL, 16'h0000, 1'b0, 16'd7);
    add("imem_ok",      idle(),                         F_RUN, 16'h0000, 1'b0, 16'd8);
    t = hz(3'd3, 1'b1, 3'd0, 1'b0); t.bt = 1'b1; t.tgt = 16'h0080;
    add("hzbr_detect",  t,                              F_LU,  16'h0080, 1'b0, 16'd8);
    add("hzbr_hold",    t,                              F_LU,  16'h0080, 1'b0, 16'd9);
    t.iv = 1'b0;
    add("hzbr_fire",    t,                              F_RED, 16'h0080, 1'b0, 16'd10);
    add("hzbr_after",   idle(),                         F_RUN, 16'h0000, 1'b0, 16'd10);
    add("rstp_detect",  br(16'h00C0, 1'b1),             F_STL, 16'h00C0, 1'b0, 16'd10);
    add("rstp_reset",   rst_in,                         F_RST, 16'h0000, 1'b0, 16'd0);
    add("rstp_after",   idle(),                         F_RUN, 16'h0000, 1'b0, 16'd0);
    t = idle(); t.hlt = 1'b1;
    add("halt_detect",  t,                              F_STL, 16'h0000, 1'b0, 16'd0);
    add("halt_hold",    idle(),                         F_STL, 16'h0000, 1'b1, 16'd1);
    add("halt_br",      br(16'h0040, 1'b0),             F_STL, 16'h0040, 1'b1, 16'd1);
    add("halt_hz",      hz(3'd3, 1'b1, 3'd0, 1'b0),     F_STL, 16'h0000, 1'b1, 16'd1);

    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].i);
      sb.push_back(tbl[k].e);
      @(negedge clk);
      e = sb.pop_front();
      chk({tbl[k].nm, ".flags"}, 32'({pc_we, fd_we, fd_flush, idex_bubble, redirect_valid}), 32'(e.f));
      chk({tbl[k].nm, ".rpc"},   32'(redirect_pc), 32'(e.rpc));
      chk({tbl[k].nm, ".halt"},  32'(halted),      32'(e.hlt));
      chk({tbl[k].nm, ".cnt"},   32'(stall_cnt),   32'(e.cnt));
      @(posedge clk);
      #1;
    end

    // Three-cycle load-use on u_dut2, then saturation of its 2-bit counter.
    drive(rst_in);
    @(posedge clk); #1;
    drive(hz(3'd3, 1'b1, 3'd0, 1'b0));
    @(negedge clk);
    chk("p3_detect", 32'({pc_we2, fd_we2, idex_bubble2}), 32'(3'b001));
    @(posedge clk); #1;
    drive(idle());
    @(negedge clk);
    chk("p3_hold1", 32'({pc_we2, fd_we2, idex_bubble2}), 32'(3'b001));
    chk("p2_hold1", 32'(pc_we), 32'(1'b0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("p3_hold2", 32'({pc_we2, fd_we2, idex_bubble2}), 32'(3'b001));
    chk("p2_done",  32'(pc_we), 32'(1'b1));
    @(posedge clk); #1;
    @(negedge clk);
    chk("p3_done", 32'({pc_we2, fd_we2, idex_bubble2}), 32'(3'b110));
    chk("p3_cnt",  32'(stall_cnt2), 32'(2'd3));
    @(posedge clk); #1;
    t = idle(); t.ims = 1'b1; t.tgt = 16'h0055;
    for (int c = 0; c < 2; c++) begin
      drive(t);
      @(negedge clk);
      chk("sat_stall", 32'({pc_we2, fd_flush2, redirect_valid2, halted2}), 32'(4'b0100));
      chk("sat_rpc",   32'(redirect_pc2), 32'(16'h0055));
      @(posedge clk); #1;
    end
    drive(idle());
    @(negedge clk);
    chk("sat_cnt", 32'(stall_cnt2), 32'(2'd3));
    chk("cnt_main", 32'(stall_cnt), 32'(16'd4));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
